// File: rtl/dot_product_datapath.sv
// dot_product_datapath: pipelined multiply-accumulate reducing one Nums_Data-element vector pair to a dot product.
// Optional macro DP_SIGNED_EN selects two's-complement operands; default build is unsigned.
module dot_product_datapath #(
    parameter int unsigned Data_Width        = 8,
    parameter int unsigned Nums_Data_in_bits = 4,
    parameter int unsigned Para_Deg          = 1
) (
    input  logic                                      clk,
    input  logic                                      Comp_reset_n,
    input  logic                                      Computing,
    input  logic                                      Rd_Valid,
    input  logic [Para_Deg*Data_Width-1:0]            Data_A,
    input  logic [Para_Deg*Data_Width-1:0]            Data_B,
    output logic [2*Data_Width+Nums_Data_in_bits-1:0] Result,
    output logic                                      Result_Valid,
    output logic                                      Busy,
    output logic                                      Overrun
);

    localparam int unsigned Nums_Data  = 1 << Nums_Data_in_bits;
    localparam int unsigned Acc_Width  = 2*Data_Width + Nums_Data_in_bits;
    localparam int unsigned Prod_Width = 2*Data_Width;
    localparam int unsigned Sum_Width  = Prod_Width + $clog2(Para_Deg);
    localparam int unsigned Cnt_Width  = Nums_Data_in_bits + 1;
    localparam int unsigned Bus_Width  = Para_Deg*Data_Width;

    localparam logic [Cnt_Width-1:0] Cnt_Full = Cnt_Width'(Nums_Data);
    localparam logic [Cnt_Width-1:0] Cnt_Step = Cnt_Width'(Para_Deg);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q;
    logic [1:0]           state_next_c;
    logic                 run_go_c;
    logic                 start_c;
    logic                 accept_c;
    logic                 final_c;
    logic                 overrun_set_c;

    logic                 s0_valid;
    logic                 s1_valid;
    logic                 s2_valid;
    logic [Bus_Width-1:0] a_q;
    logic [Bus_Width-1:0] b_q;
    logic [Cnt_Width-1:0] issue_cnt;
    logic [Cnt_Width-1:0] done_cnt;
    logic [Acc_Width-1:0] acc_q;
    logic [Acc_Width-1:0] acc_next_c;

`ifdef DP_SIGNED_EN
    logic signed [Prod_Width-1:0] prod_c;
    logic signed [Sum_Width-1:0]  lane_sum_c;
    logic signed [Sum_Width-1:0]  sum_q;
`else
    logic [Prod_Width-1:0] prod_c;
    logic [Sum_Width-1:0]  lane_sum_c;
    logic [Sum_Width-1:0]  sum_q;
`endif

    // Lane products summed into one group contribution
    always_comb begin
        prod_c     = '0;
        lane_sum_c = '0;
        for (int i = 0; i < int'(Para_Deg); i++) begin
`ifdef DP_SIGNED_EN
            prod_c = Prod_Width'($signed(a_q[i*Data_Width +: Data_Width]))
                   * Prod_Width'($signed(b_q[i*Data_Width +: Data_Width]));
`else
            prod_c = Prod_Width'(a_q[i*Data_Width +: Data_Width])
                   * Prod_Width'(b_q[i*Data_Width +: Data_Width]);
`endif
            lane_sum_c = lane_sum_c + Sum_Width'(prod_c);
        end
    end

    // Control decode and next state
    always_comb begin
        state_next_c  = state_q;
        run_go_c      = (state_q == RUN) && Computing;
        start_c       = (state_q == IDLE) && Computing;
        accept_c      = run_go_c && Rd_Valid && (issue_cnt < Cnt_Full);
        final_c       = run_go_c && s2_valid && ((done_cnt + Cnt_Step) == Cnt_Full);
        overrun_set_c = Rd_Valid && ((state_q == DONE) || (run_go_c && (issue_cnt == Cnt_Full)));
        acc_next_c    = acc_q + Acc_Width'(sum_q);
        case (state_q)
            IDLE: if (Computing) state_next_c = RUN;
            RUN: begin
                if (!Computing)   state_next_c = IDLE;
                else if (final_c) state_next_c = DONE;
            end
            DONE: if (!Computing) state_next_c = IDLE;
            default: state_next_c = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Comp_reset_n) state_q <= IDLE;
        else               state_q <= state_next_c;
    end

    // Pipeline stages advance only while running; leaving RUN flushes in-flight groups
    always_ff @(posedge clk) begin
        if (!Comp_reset_n) begin
            s0_valid     <= 1'b0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            issue_cnt    <= '0;
            done_cnt     <= '0;
            acc_q        <= '0;
            Result       <= '0;
            Result_Valid <= 1'b0;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            s0_valid     <= accept_c;
            s1_valid     <= run_go_c && s0_valid;
            s2_valid     <= run_go_c && s1_valid;
            Result_Valid <= final_c;
            Busy         <= (state_next_c == RUN);
            if (run_go_c && s0_valid) begin
                a_q <= Data_A;
                b_q <= Data_B;
            end
            if (run_go_c && s1_valid) sum_q <= lane_sum_c;
            if (start_c) begin
                issue_cnt <= '0;
                done_cnt  <= '0;
                acc_q     <= '0;
                Overrun   <= 1'b0;
            end else begin
                if (accept_c) issue_cnt <= issue_cnt + Cnt_Step;
                if (run_go_c && s2_valid) begin
                    acc_q    <= acc_next_c;
                    done_cnt <= done_cnt + Cnt_Step;
                end
                if (overrun_set_c) Overrun <= 1'b1;
            end
            if (final_c) Result <= acc_next_c;
        end
    end

endmodule

// File: tb/tb_dot_product_datapath.sv
// Bench for dot_product_datapath: directed and randomized vectors against a plain-arithmetic dot-product model.
module tb_dot_product_datapath;

    localparam int unsigned DW = 8;
    localparam int unsigned ND = 16;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          Comp_reset_n;
    logic          Computing;
    logic          Rd_Valid;
    logic [DW-1:0] Data_A;
    logic [DW-1:0] Data_B;
    logic [AW-1:0] Result;
    logic          Result_Valid;
    logic          Busy;
    logic          Overrun;

    always #5 clk = ~clk;

    dot_product_datapath dut (
        .clk          (clk),
        .Comp_reset_n (Comp_reset_n),
        .Computing    (Computing),
        .Rd_Valid     (Rd_Valid),
        .Data_A       (Data_A),
        .Data_B       (Data_B),
        .Result       (Result),
        .Result_Valid (Result_Valid),
        .Busy         (Busy),
        .Overrun      (Overrun)
    );

    int compared   = 0;
    int mismatched = 0;

    int            cycle = 0;
    int            rv_total = 0;
    int            pulse_cycle = 0;
    logic [AW-1:0] pulse_result = '0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (Result_Valid === 1'b1) begin
            rv_total     = rv_total + 1;
            pulse_cycle  = cycle;
            pulse_result = Result;
        end
    end

    logic [DW-1:0] va [ND];
    logic [DW-1:0] vb [ND];
    int            gap [ND];
    logic          have_pend = 1'b0;
    logic [DW-1:0] pend_a, pend_b;
    int            last_rv, first_rv, last_elem, base;
    logic [AW-1:0] exp_last;

    // SRAM read data appears one cycle after its read enable
    task automatic drive_cycle(input logic comp, input logic rv, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        Computing = comp;
        Rd_Valid  = rv;
        Data_A    = have_pend ? pend_a : DW'($urandom);
        Data_B    = have_pend ? pend_b : DW'($urandom);
        have_pend = rv;
        pend_a    = a;
        pend_b    = b;
        if (rv) last_rv = cycle;
    endtask

    task automatic run_vector(input int n, input logic extra_rv);
        base = rv_total;
        drive_cycle(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, 1'b1, va[i], vb[i]);
            if (i == 0) first_rv = last_rv;
            for (int g = 0; g < gap[i]; g++) drive_cycle(1'b1, 1'b0, '0, '0);
        end
        last_elem = last_rv;
        if (extra_rv) drive_cycle(1'b1, 1'b1, 8'hAA, 8'h55);
        for (int k = 0; k < 8; k++) drive_cycle(1'b1, 1'b0, '0, '0);
    endtask

    function automatic logic [AW-1:0] model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
`ifdef DP_SIGNED_EN
            s += longint'($signed(va[i])) * longint'($signed(vb[i]));
`else
            s += longint'(va[i]) * longint'(vb[i]);
`endif
        end
        return AW'(s);
    endfunction

    task automatic clear_gaps();
        for (int i = 0; i < int'(ND); i++) gap[i] = 0;
    endtask

    task automatic test_reset();
        Comp_reset_n = 1'b0; Computing = 1'b0; Rd_Valid = 1'b0; Data_A = '0; Data_B = '0;
        repeat (3) @(negedge clk);
        compared++; if (Result !== '0) begin mismatched++; $display("FAIL reset_result: got %0d expected 0", Result); end
        compared++; if (Result_Valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", Result_Valid); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        compared++; if (Overrun !== 1'b0) begin mismatched++; $display("FAIL reset_overrun: got %b expected 0", Overrun); end
        Comp_reset_n = 1'b1;
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_contiguous();
        clear_gaps();
        for (int i = 0; i < int'(ND); i++) begin va[i] = DW'(i + 1); vb[i] = 8'd1; end
        run_vector(ND, 1'b0);
        exp_last = 20'd136;
        compared++; if (rv_total - base != 1) begin mismatched++; $display("FAIL contig_pulses: got %0d expected 1", rv_total - base); end
        compared++; if (pulse_result !== exp_last) begin mismatched++; $display("FAIL contig_result: got %0d expected %0d", pulse_result, exp_last); end
        compared++; if (pulse_cycle != last_elem + 4) begin mismatched++; $display("FAIL contig_latency: got %0d expected %0d", pulse_cycle - last_elem, 4); end
        compared++; if (pulse_cycle - first_rv != int'(ND) + 3) begin mismatched++; $display("FAIL contig_total: got %0d expected %0d", pulse_cycle - first_rv, ND + 3); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL contig_busy_after: got %b expected 0", Busy); end
        compared++; if (Result !== exp_last) begin mismatched++; $display("FAIL contig_hold: got %0d expected %0d", Result, exp_last); end
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_bubbles();
        clear_gaps();
        gap[4] = 1; gap[9] = 2;
        for (int i = 0; i < int'(ND); i++) begin va[i] = DW'(i + 1); vb[i] = DW'(i + 1); end
        run_vector(ND, 1'b0);
        exp_last = 20'd1496;
        compared++; if (rv_total - base != 1) begin mismatched++; $display("FAIL bubble_pulses: got %0d expected 1", rv_total - base); end
        compared++; if (pulse_result !== exp_last) begin mismatched++; $display("FAIL bubble_result: got %0d expected %0d", pulse_result, exp_last); end
        compared++; if (pulse_cycle - first_rv != int'(ND) + 3 + 3) begin mismatched++; $display("FAIL bubble_latency: got %0d expected %0d", pulse_cycle - first_rv, ND + 6); end
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_max();
        clear_gaps();
`ifdef DP_SIGNED_EN
        for (int i = 0; i < int'(ND); i++) begin va[i] = 8'h80; vb[i] = 8'h80; end
        run_vector(ND, 1'b0);
        compared++; if (pulse_result !== 20'd262144) begin mismatched++; $display("FAIL max_neg_result: got %0h expected %0h", pulse_result, 20'd262144); end
        drive_cycle(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < int'(ND); i++) begin va[i] = 8'hFF; vb[i] = 8'h01; end
        run_vector(ND, 1'b0);
        exp_last = 20'hFFFF0;
        compared++; if (pulse_result !== exp_last) begin mismatched++; $display("FAIL minus_one_result: got %0h expected %0h", pulse_result, exp_last); end
`else
        for (int i = 0; i < int'(ND); i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
        run_vector(ND, 1'b0);
        exp_last = 20'd1040400;
        compared++; if (pulse_result !== exp_last) begin mismatched++; $display("FAIL max_result: got %0d expected %0d", pulse_result, exp_last); end
`endif
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_overrun();
        clear_gaps();
        for (int i = 0; i < int'(ND); i++) begin va[i] = DW'(i + 1); vb[i] = 8'd1; end
        run_vector(ND, 1'b1);
        exp_last = 20'd136;
        compared++; if (Overrun !== 1'b1) begin mismatched++; $display("FAIL overrun_set: got %b expected 1", Overrun); end
        compared++; if (rv_total - base != 1) begin mismatched++; $display("FAIL overrun_pulses: got %0d expected 1", rv_total - base); end
        compared++; if (Result !== exp_last) begin mismatched++; $display("FAIL overrun_result: got %0d expected %0d", Result, exp_last); end
        drive_cycle(1'b0, 1'b0, '0, '0);
        drive_cycle(1'b1, 1'b0, '0, '0);
        drive_cycle(1'b1, 1'b0, '0, '0);
        compared++; if (Overrun !== 1'b0) begin mismatched++; $display("FAIL overrun_clear: got %b expected 0", Overrun); end
        compared++; if (Busy !== 1'b1) begin mismatched++; $display("FAIL overrun_restart_busy: got %b expected 1", Busy); end
        drive_cycle(1'b0, 1'b0, '0, '0);
        drive_cycle(1'b0, 1'b0, '0, '0);
        // Read enable while parked in DONE
        run_vector(ND, 1'b0);
        compared++; if (Overrun !== 1'b0) begin mismatched++; $display("FAIL done_no_overrun: got %b expected 0", Overrun); end
        drive_cycle(1'b1, 1'b1, 8'h11, 8'h22);
        drive_cycle(1'b1, 1'b0, '0, '0);
        compared++; if (Overrun !== 1'b1) begin mismatched++; $display("FAIL done_overrun: got %b expected 1", Overrun); end
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_abort();
        clear_gaps();
        for (int i = 0; i < int'(ND); i++) begin va[i] = DW'($urandom); vb[i] = DW'($urandom); end
        base = rv_total;
        drive_cycle(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b1, va[i], vb[i]);
        for (int k = 0; k < 8; k++) drive_cycle(1'b0, 1'b0, '0, '0);
        compared++; if (rv_total - base != 0) begin mismatched++; $display("FAIL abort_pulses: got %0d expected 0", rv_total - base); end
        compared++; if (Result !== exp_last) begin mismatched++; $display("FAIL abort_hold: got %0d expected %0d", Result, exp_last); end
        compared++; if (Busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %b expected 0", Busy); end
        run_vector(ND, 1'b0);
        exp_last = model_sum(ND);
        compared++; if (pulse_result !== exp_last || rv_total - base != 1) begin mismatched++; $display("FAIL abort_restart: got %0d (%0d pulses) expected %0d (1 pulse)", pulse_result, rv_total - base, exp_last); end
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset_mid_run();
        clear_gaps();
        for (int i = 0; i < int'(ND); i++) begin va[i] = DW'($urandom); vb[i] = DW'($urandom); end
        base = rv_total;
        drive_cycle(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, va[i], vb[i]);
        @(negedge clk);
        Comp_reset_n = 1'b0; Computing = 1'b0; Rd_Valid = 1'b0; have_pend = 1'b0;
        @(negedge clk);
        compared++; if (Result !== '0) begin mismatched++; $display("FAIL midreset_result: got %0d expected 0", Result); end
        compared++; if (Busy !== 1'b0 || Result_Valid !== 1'b0 || Overrun !== 1'b0) begin mismatched++; $display("FAIL midreset_flags: got busy=%b valid=%b overrun=%b expected 0 0 0", Busy, Result_Valid, Overrun); end
        Comp_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 8'hFF, 8'hFF);
        for (int k = 0; k < 6; k++) drive_cycle(1'b0, 1'b0, '0, '0);
        compared++; if (Busy !== 1'b0 || Overrun !== 1'b0 || rv_total - base != 0) begin mismatched++; $display("FAIL idle_ignore: got busy=%b overrun=%b pulses=%0d expected 0 0 0", Busy, Overrun, rv_total - base); end
        run_vector(ND, 1'b0);
        exp_last = model_sum(ND);
        compared++; if (pulse_result !== exp_last || rv_total - base != 1) begin mismatched++; $display("FAIL midreset_restart: got %0d (%0d pulses) expected %0d (1 pulse)", pulse_result, rv_total - base, exp_last); end
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < int'(ND); i++) begin
                va[i]  = DW'($urandom);
                vb[i]  = DW'($urandom);
                gap[i] = int'($urandom_range(0, 2));
            end
            run_vector(ND, 1'b0);
            exp_last = model_sum(ND);
            compared++; if (pulse_result !== exp_last || rv_total - base != 1) begin mismatched++; $display("FAIL random_result[%0d]: got %0d (%0d pulses) expected %0d (1 pulse)", t, pulse_result, rv_total - base, exp_last); end
            compared++; if (pulse_cycle != last_elem + 4) begin mismatched++; $display("FAIL random_latency[%0d]: got %0d expected 4", t, pulse_cycle - last_elem); end
            drive_cycle(1'b0, 1'b0, '0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_bubbles();
        test_max();
        test_overrun();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
